// File: rtl/ld_cell_monitor.sv
// ld_cell_monitor: rider-detect front end.
// Turns left/right load-cell readings into sum/difference flags with
// hysteresis through a 3-stage pipeline. It also holds the stability timer
// that the steer-enable state machine clears and polls.
// Build option: FAST_SIM_EN shortens the stability timer to 15 bits for
// simulation. The default build uses the full TMR_BITS width.
module ld_cell_monitor #(
    parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
    parameter logic [12:0] WT_HYST      = 13'h0040,
    parameter int          TMR_BITS     = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        clr_tmr,
    output logic        sum_gt_min,
    output logic        sum_lt_min,
    output logic        diff_gt_1_4,
    output logic        diff_gt_15_16,
    output logic        tmr_full
);

    // Hysteresis band edges. WT_HYST < MIN_RIDER_WT, so the low edge cannot underflow.
    localparam logic [12:0] SUM_HI_THR = MIN_RIDER_WT + WT_HYST;
    localparam logic [12:0] SUM_LO_THR = MIN_RIDER_WT - WT_HYST;

`ifdef FAST_SIM_EN
    // Short timer for simulation. The upper timer bits are never built, so they read as 0.
    localparam int TMR_EFF = (TMR_BITS < 15) ? TMR_BITS : 15;
`else
    localparam int TMR_EFF = TMR_BITS;
`endif
    localparam logic [TMR_EFF-1:0] TMR_ONE = {{(TMR_EFF-1){1'b0}}, 1'b1};

    // Stage 1: captured raw readings
    logic [11:0] p1_lft_q, p1_rght_q;
    logic        p1_vld_q;
    // Stage 2: sum and absolute difference
    logic [12:0] p2_sum_q, p2_sum_d;
    logic [11:0] p2_adiff_q, p2_adiff_d;
    logic        p2_vld_q;
    // Stage 3: flags
    logic        gt_min_q, lt_min_q, d14_q, d1516_q;
    logic        gt_min_d, lt_min_d, d14_d, d1516_d;
    // Stability timer
    logic [TMR_EFF-1:0] tmr_q, tmr_d;

    // Stage 1: latch a reading only when it is strobed; track validity every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_lft_q  <= '0;
            p1_rght_q <= '0;
            p1_vld_q  <= 1'b0;
        end else begin
            p1_vld_q <= vld;
            if (vld) begin
                p1_lft_q  <= lft_ld;
                p1_rght_q <= rght_ld;
            end
        end
    end

    // Stage 2 arithmetic: the zero-extended sum cannot overflow 13 bits, and the
    // difference is taken larger-minus-smaller so it stays unsigned
    always_comb begin
        p2_sum_d = {1'b0, p1_lft_q} + {1'b0, p1_rght_q};
        if (p1_lft_q >= p1_rght_q) begin
            p2_adiff_d = p1_lft_q - p1_rght_q;
        end else begin
            p2_adiff_d = p1_rght_q - p1_lft_q;
        end
    end

    // Stage 2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2_sum_q   <= '0;
            p2_adiff_q <= '0;
            p2_vld_q   <= 1'b0;
        end else begin
            p2_vld_q <= p1_vld_q;
            if (p1_vld_q) begin
                p2_sum_q   <= p2_sum_d;
                p2_adiff_q <= p2_adiff_d;
            end
        end
    end

    // Stage 3 compares: all strict and unsigned. The two sum flags use thresholds
    // that do not overlap, so they are never set together
    always_comb begin
        gt_min_d = p2_sum_q > SUM_HI_THR;
        lt_min_d = p2_sum_q < SUM_LO_THR;
        d14_d    = {1'b0, p2_adiff_q} > (p2_sum_q >> 2);
        d1516_d  = {1'b0, p2_adiff_q} > (p2_sum_q - (p2_sum_q >> 4));
    end

    // Stage 3 register: flags change only when a valid reading arrives, and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_min_q <= 1'b0;
            lt_min_q <= 1'b1;
            d14_q    <= 1'b0;
            d1516_q  <= 1'b0;
        end else if (p2_vld_q) begin
            gt_min_q <= gt_min_d;
            lt_min_q <= lt_min_d;
            d14_q    <= d14_d;
            d1516_q  <= d1516_d;
        end
    end

    // Timer next state: a clear wins; otherwise count up and stop at all-ones
    always_comb begin
        if (clr_tmr) begin
            tmr_d = '0;
        end else if (&tmr_q) begin
            tmr_d = tmr_q;
        end else begin
            tmr_d = tmr_q + TMR_ONE;
        end
    end

    // Timer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign sum_gt_min    = gt_min_q;
    assign sum_lt_min    = lt_min_q;
    assign diff_gt_1_4   = d14_q;
    assign diff_gt_15_16 = d1516_q;
    assign tmr_full      = &tmr_q;

endmodule

// File: tb/tb_ld_cell_monitor.sv
// tb_ld_cell_monitor: directed vectors for ld_cell_monitor.
// A reading model built from plain arithmetic is checked against the DUT on
// every cycle. Literal expectations worked out by hand pin that model.
// The timer is built 15 bits wide so it fills within the run.
module tb_ld_cell_monitor;

    localparam int TB_TMR_BITS = 15;
    localparam int TMR_MAX     = (1 << TB_TMR_BITS) - 1;
    localparam int HI_THR      = 576;   // 0x200 + 0x40
    localparam int LO_THR      = 448;   // 0x200 - 0x40

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        clr_tmr = 1'b0;
    logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full;

    int vectors = 0;
    int miscompares = 0;

    ld_cell_monitor #(.TMR_BITS(TB_TMR_BITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld          (vld),
        .lft_ld       (lft_ld),
        .rght_ld      (rght_ld),
        .clr_tmr      (clr_tmr),
        .sum_gt_min   (sum_gt_min),
        .sum_lt_min   (sum_lt_min),
        .diff_gt_1_4  (diff_gt_1_4),
        .diff_gt_15_16(diff_gt_15_16),
        .tmr_full     (tmr_full)
    );

    always #10 clk = ~clk;

    task automatic cmp(input string nm, input logic act, input logic exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int l;
        int r;
    } rd_t;

    rd_t pend[$];
    int  edge_n = 0;
    bit  m_gt = 1'b0, m_lt = 1'b1, m_d14 = 1'b0, m_d1516 = 1'b0;
    int  m_tmr = 0;

    // A reading strobed on edge k appears on the flags after edge k+2,
    // which is the third edge after vld was driven.
    initial begin
        rd_t rd;
        int  s, ad;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pend.delete();
                edge_n  = 0;
                m_gt    = 1'b0;
                m_lt    = 1'b1;
                m_d14   = 1'b0;
                m_d1516 = 1'b0;
                m_tmr   = 0;
            end else begin
                edge_n = edge_n + 1;
                if (vld) pend.push_back('{due: edge_n + 2, l: int'(lft_ld), r: int'(rght_ld)});
                while (pend.size() > 0 && pend[0].due == edge_n) begin
                    rd = pend.pop_front();
                    s  = rd.l + rd.r;
                    ad = (rd.l > rd.r) ? rd.l - rd.r : rd.r - rd.l;
                    m_gt    = s > HI_THR;
                    m_lt    = s < LO_THR;
                    m_d14   = ad > s / 4;
                    m_d1516 = ad > s - s / 16;
                end
                if (clr_tmr) m_tmr = 0;
                else if (m_tmr < TMR_MAX) m_tmr = m_tmr + 1;
            end
        end
    end

    // Compare the model with the DUT on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            cmp("mdl_sum_gt_min", sum_gt_min, m_gt);
            cmp("mdl_sum_lt_min", sum_lt_min, m_lt);
            cmp("mdl_diff_gt_1_4", diff_gt_1_4, m_d14);
            cmp("mdl_diff_gt_15_16", diff_gt_15_16, m_d1516);
            cmp("mdl_tmr_full", tmr_full, m_tmr == TMR_MAX);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk_flags(input string nm, input logic egt, input logic elt,
                             input logic ed14, input logic ed1516);
        cmp({nm, "_gt"}, sum_gt_min, egt);
        cmp({nm, "_lt"}, sum_lt_min, elt);
        cmp({nm, "_d14"}, diff_gt_1_4, ed14);
        cmp({nm, "_d1516"}, diff_gt_15_16, ed1516);
    endtask

    // Drive one reading at a falling edge, then check three clocks later
    task automatic send_chk(input string nm, input int l, input int r, input logic egt,
                            input logic elt, input logic ed14, input logic ed1516);
        vld     = 1'b1;
        lft_ld  = 12'(l);
        rght_ld = 12'(r);
        @(negedge clk);
        vld = 1'b0;
        repeat (2) @(negedge clk);
        $display("reading lft=%0d rght=%0d -> gt=%b lt=%b d14=%b d1516=%b",
                 l, r, sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16);
        chk_flags(nm, egt, elt, ed14, ed1516);
    endtask

    initial begin
        int   bl[5];
        int   br[5];
        logic bexp[5][4];
        bl = '{300, 200, 240, 500, 700};
        br = '{300, 240, 260, 100, 10};
        bexp = '{'{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0},
                 '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b1, 1'b0},
                 '{1'b1, 1'b0, 1'b1, 1'b1}};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset values hold while the inputs stay idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_flags("reset_hold", 1'b0, 1'b1, 1'b0, 1'b0);
            cmp("reset_hold_tmr", tmr_full, 1'b0);
        end
        $display("reset hold: 10 cycles checked");

        // Single readings, including the exact thresholds
        send_chk("c2_600",    300,  300,  1'b1, 1'b0, 1'b0, 1'b0);
        send_chk("c3_440",    200,  240,  1'b0, 1'b1, 1'b0, 1'b0);
        send_chk("c3_500",    240,  260,  1'b0, 1'b0, 1'b0, 1'b0);
        send_chk("c4_500_100", 500, 100,  1'b1, 1'b0, 1'b1, 1'b0);
        send_chk("c4_700_10", 700,  10,   1'b1, 1'b0, 1'b1, 1'b1);
        send_chk("sum_eq_hi", 288,  288,  1'b0, 1'b0, 1'b0, 1'b0);
        send_chk("sum_eq_lo", 224,  224,  1'b0, 1'b0, 1'b0, 1'b0);
        send_chk("d14_eq",    250,  150,  1'b0, 1'b1, 1'b0, 1'b0);
        send_chk("d1516_eq",  31,   1,    1'b0, 1'b1, 1'b1, 1'b0);
        send_chk("d1516_eq_r", 1,   31,   1'b0, 1'b1, 1'b1, 1'b0);
        send_chk("zero",      0,    0,    1'b0, 1'b1, 1'b0, 1'b0);
        send_chk("max_both",  4095, 4095, 1'b1, 1'b0, 1'b0, 1'b0);
        send_chk("max_one",   4095, 0,    1'b1, 1'b0, 1'b1, 1'b1);

        // Back-to-back readings appear on consecutive cycles, in order
        for (int i = 0; i < 8; i++) begin
            if (i >= 3) begin
                $display("b2b result %0d -> gt=%b lt=%b d14=%b d1516=%b", i - 3,
                         sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16);
                chk_flags("b2b", bexp[i-3][0], bexp[i-3][1], bexp[i-3][2], bexp[i-3][3]);
            end
            if (i < 5) begin
                vld     = 1'b1;
                lft_ld  = 12'(bl[i]);
                rght_ld = 12'(br[i]);
            end else begin
                vld = 1'b0;
            end
            @(negedge clk);
        end

        // Reset one clock after a strobe: that reading must never appear
        vld     = 1'b1;
        lft_ld  = 12'd300;
        rght_ld = 12'd300;
        @(negedge clk);
        vld   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_flags("rst_discard", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        $display("mid-run reset: in-flight reading discarded");
        send_chk("post_rst", 500, 100, 1'b1, 1'b0, 1'b1, 1'b0);

        // Timer: full exactly TMR_MAX clocks after the clearing edge
        clr_tmr = 1'b1;
        @(negedge clk);
        clr_tmr = 1'b0;
        cmp("tmr_after_clr", tmr_full, 1'b0);
        repeat (TMR_MAX - 1) @(posedge clk);
        @(negedge clk);
        cmp("tmr_one_short", tmr_full, 1'b0);
        @(negedge clk);
        cmp("tmr_full_exact", tmr_full, 1'b1);
        $display("timer reached full after %0d clocks", TMR_MAX);
        repeat (20) @(negedge clk);
        cmp("tmr_saturate", tmr_full, 1'b1);
        clr_tmr = 1'b1;
        @(negedge clk);
        clr_tmr = 1'b0;
        cmp("tmr_clr_pulse", tmr_full, 1'b0);
        clr_tmr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("tmr_clr_held", tmr_full, 1'b0);
        end
        clr_tmr = 1'b0;
        @(negedge clk);
        $display("timer clear checks done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
